dnn_layer_seq: RTL and testbench

- Layer sequencer in front of tiny_dnn_top.
- Holds a small table of per-layer descriptors. For each layer it steps tiny_dnn_top through bias load, weight load and sample run by driving bwrite/wwrite/run and the geometry buses.
- Tracks progress by monitoring the src/dst stream handshakes. Software writes the table, pulses start, then only supplies the streams.

---
 rtl/dnn_seq_pkg.sv | 58 +++++
 rtl/dnn_layer_seq_if.sv | 73 +++++++
 rtl/dnn_desc_ram.sv | 33 +++
 rtl/dnn_layer_seq.sv | 168 ++++++++++++++++
 tb/tb_dnn_layer_seq.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dnn_seq_pkg.sv
// Shared types for the dnn layer sequencer: descriptor layout,
// FSM states and geometry field widths.
package dnn_seq_pkg;

    localparam int DESC_W = 128;
    localparam int NS_W   = 16;

    localparam int SS_W = 12;
    localparam int ID_W = 4;
    localparam int IS_W = 10;
    localparam int IH_W = 5;
    localparam int IW_W = 5;
    localparam int DS_W = 12;
    localparam int OD_W = 4;
    localparam int OS_W = 10;
    localparam int OH_W = 5;
    localparam int OW_W = 5;
    localparam int FS_W = 8;
    localparam int KH_W = 3;
    localparam int KW_W = 3;
    localparam int BC_W = 8;
    localparam int WC_W = 13;

    localparam int RSV_W = DESC_W - 86 - BC_W - WC_W - NS_W;

    // kw sits at bit 0; nsamp is the top field, spare bits above it
    typedef struct packed {
        logic [RSV_W-1:0] rsvd;
        logic [NS_W-1:0]  nsamp;
        logic [WC_W-1:0]  wcnt;
        logic [BC_W-1:0]  bcnt;
        logic [SS_W-1:0]  ss;
        logic [ID_W-1:0]  id;
        logic [IS_W-1:0]  is;
        logic [IH_W-1:0]  ih;
        logic [IW_W-1:0]  iw;
        logic [DS_W-1:0]  ds;
        logic [OD_W-1:0]  od;
        logic [OS_W-1:0]  os;
        logic [OH_W-1:0]  oh;
        logic [OW_W-1:0]  ow;
        logic [FS_W-1:0]  fs;
        logic [KH_W-1:0]  kh;
        logic [KW_W-1:0]  kw;
    } layer_desc_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD_B,
        GAP_B,
        LOAD_W,
        GAP_W,
        RUN,
        NEXT
    } seq_state_t;

endpackage

// File: rtl/dnn_layer_seq_if.sv
// Sequencer bus: config/start/abort, monitored streams, mode
// controls and geometry. Optional perf_sel/perf_cycles (SEQ_PERF_EN).
interface dnn_layer_seq_if
    import dnn_seq_pkg::*;
#(
    parameter int LW = 3
) ();

    logic              cfg_we;
    logic [LW-1:0]     cfg_layer;
    logic [DESC_W-1:0] cfg_data;
    logic              start;
    logic              abort;
    logic [LW:0]       num_layers;
    logic              src_valid;
    logic              src_ready;
    logic              dst_valid;
    logic              dst_ready;
    logic              run;
    logic              wwrite;
    logic              bwrite;
    logic [SS_W-1:0]   ss;
    logic [ID_W-1:0]   id;
    logic [IS_W-1:0]   is;
    logic [IH_W-1:0]   ih;
    logic [IW_W-1:0]   iw;
    logic [DS_W-1:0]   ds;
    logic [OD_W-1:0]   od;
    logic [OS_W-1:0]   os;
    logic [OH_W-1:0]   oh;
    logic [OW_W-1:0]   ow;
    logic [FS_W-1:0]   fs;
    logic [KH_W-1:0]   kh;
    logic [KW_W-1:0]   kw;
    logic              busy;
    logic              done;
    logic [LW-1:0]     layer_idx;
`ifdef SEQ_PERF_EN
    logic [LW-1:0]     perf_sel;
    logic [31:0]       perf_cycles;
`endif

    modport master (
        output cfg_we, cfg_layer, cfg_data,
        output start, abort, num_layers,
        output src_valid, src_ready,
        output dst_valid, dst_ready,
`ifdef SEQ_PERF_EN
        output perf_sel,
        input  perf_cycles,
`endif
        input  run, wwrite, bwrite,
        input  ss, id, is, ih, iw, ds,
        input  od, os, oh, ow, fs, kh, kw,
        input  busy, done, layer_idx
    );

    modport slave (
        input  cfg_we, cfg_layer, cfg_data,
        input  start, abort, num_layers,
        input  src_valid, src_ready,
        input  dst_valid, dst_ready,
`ifdef SEQ_PERF_EN
        input  perf_sel,
        output perf_cycles,
`endif
        output run, wwrite, bwrite,
        output ss, id, is, ih, iw, ds,
        output od, os, oh, ow, fs, kh, kw,
        output busy, done, layer_idx
    );

endinterface

// File: rtl/dnn_desc_ram.sv
// Descriptor table: one write port, registered read port.
// Ports: we/waddr/wdata write; re/raddr load rdata (reset to 0).
module dnn_desc_ram
    import dnn_seq_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    parameter int LW         = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [LW-1:0]     waddr,
    input  logic [DESC_W-1:0] wdata,
    input  logic              re,
    input  logic [LW-1:0]     raddr,
    output logic [DESC_W-1:0] rdata
);

    logic [DESC_W-1:0] mem [MAX_LAYERS];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/dnn_layer_seq.sv
// Layer sequencer driving tiny_dnn_top through bias/weight/run.
// Ports: clk, rst_n (sync, active low), bus (slave). Macro SEQ_PERF_EN.
module dnn_layer_seq
    import dnn_seq_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    parameter int LW         = 3
) (
    input logic            clk,
    input logic            rst_n,
    dnn_layer_seq_if.slave bus
);

    seq_state_t        state_q, state_nxt;
    logic [LW-1:0]     layer_q;
    layer_desc_t       desc_q;
    logic [WC_W-1:0]   beat_q;
    logic [DS_W-1:0]   dcnt_q;
    logic [NS_W-1:0]   scnt_q;
    logic              run_q, wwrite_q, bwrite_q;
    logic              busy_q, done_q;
    logic              src_beat, dst_beat;
    logic              ld_hit, ds_hit, last;
    logic [WC_W-1:0]   lim;
    logic [LW:0]       nl_eff;
    logic              unused_rsvd;

    assign src_beat = bus.src_valid & bus.src_ready;
    assign dst_beat = bus.dst_valid & bus.dst_ready;

    assign lim = (state_q == LOAD_B) ?
                 {{(WC_W-BC_W){1'b0}}, desc_q.bcnt} :
                 desc_q.wcnt;
    assign ld_hit = src_beat && (beat_q == lim);
    assign ds_hit = dst_beat && (dcnt_q == desc_q.ds);

    // a layer count of zero runs a single layer
    assign nl_eff = (bus.num_layers == '0) ?
                    {{LW{1'b0}}, 1'b1} : bus.num_layers;
    assign last = ({1'b0, layer_q} + {{LW{1'b0}}, 1'b1}) == nl_eff;

    dnn_desc_ram #(
        .MAX_LAYERS(MAX_LAYERS),
        .LW        (LW)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (bus.cfg_we && (state_q == IDLE)),
        .waddr(bus.cfg_layer),
        .wdata(bus.cfg_data),
        .re   (state_q == FETCH),
        .raddr(layer_q),
        .rdata(desc_q)
    );

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            IDLE:   if (bus.start) state_nxt = FETCH;
            FETCH:  state_nxt = LOAD_B;
            LOAD_B: if (ld_hit) state_nxt = GAP_B;
            GAP_B:  if (!bus.src_valid) state_nxt = LOAD_W;
            LOAD_W: if (ld_hit) state_nxt = GAP_W;
            GAP_W:  if (!bus.src_valid) state_nxt = RUN;
            RUN: begin
                if (ds_hit && (scnt_q == desc_q.nsamp))
                    state_nxt = NEXT;
            end
            NEXT:   state_nxt = last ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            layer_q  <= '0;
            beat_q   <= '0;
            dcnt_q   <= '0;
            scnt_q   <= '0;
            run_q    <= 1'b0;
            wwrite_q <= 1'b0;
            bwrite_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            run_q    <= (state_nxt == RUN);
            wwrite_q <= (state_nxt == LOAD_W) || (state_nxt == GAP_W);
            bwrite_q <= (state_nxt == LOAD_B) || (state_nxt == GAP_B);
            busy_q   <= (state_nxt != IDLE);
            done_q   <= (state_q == NEXT) && last && !bus.abort;

            if (state_q == IDLE && bus.start && !bus.abort)
                layer_q <= '0;
            else if (state_q == NEXT && !last && !bus.abort)
                layer_q <= layer_q + {{(LW-1){1'b0}}, 1'b1};

            // any state change zeroes counters, covering every entry
            if (state_nxt != state_q) begin
                beat_q <= '0;
                dcnt_q <= '0;
                scnt_q <= '0;
            end else if ((state_q == LOAD_B || state_q == LOAD_W)
                         && src_beat) begin
                beat_q <= beat_q + 13'd1;
            end else if (state_q == RUN && dst_beat) begin
                if (dcnt_q == desc_q.ds) begin
                    dcnt_q <= '0;
                    scnt_q <= scnt_q + 16'd1;
                end else begin
                    dcnt_q <= dcnt_q + 12'd1;
                end
            end
        end
    end

    assign bus.run       = run_q;
    assign bus.wwrite    = wwrite_q;
    assign bus.bwrite    = bwrite_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.layer_idx = layer_q;
    assign bus.ss        = desc_q.ss;
    assign bus.id        = desc_q.id;
    assign bus.is        = desc_q.is;
    assign bus.ih        = desc_q.ih;
    assign bus.iw        = desc_q.iw;
    assign bus.ds        = desc_q.ds;
    assign bus.od        = desc_q.od;
    assign bus.os        = desc_q.os;
    assign bus.oh        = desc_q.oh;
    assign bus.ow        = desc_q.ow;
    assign bus.fs        = desc_q.fs;
    assign bus.kh        = desc_q.kh;
    assign bus.kw        = desc_q.kw;

    assign unused_rsvd = ^desc_q.rsvd;

`ifdef SEQ_PERF_EN
    logic [31:0] perf_q;
    logic [31:0] perf_mem [MAX_LAYERS];

    // counts FETCH through the last RUN cycle, saturating
    always_ff @(posedge clk) begin
        if (!rst_n)
            perf_q <= '0;
        else if (state_q == FETCH)
            perf_q <= 32'd1;
        else if (perf_q != 32'hFFFF_FFFF)
            perf_q <= perf_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.start && !bus.abort) begin
            for (int i = 0; i < MAX_LAYERS; i++)
                perf_mem[i] <= '0;
        end else if (state_q == NEXT) begin
            perf_mem[layer_q] <= perf_q;
        end
    end

    assign bus.perf_cycles = perf_mem[bus.perf_sel];
`endif

endmodule

// File: tb/tb_dnn_layer_seq.sv
// Directed bench for dnn_layer_seq: reset, single and dual layer
// sequences, gap hold, run beat counting, abort and mid-run reset.
module tb_dnn_layer_seq;
    import dnn_seq_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   ovl = 0;

    dnn_layer_seq_if #(.LW(3)) bus ();

    dnn_layer_seq #(
        .MAX_LAYERS(8),
        .LW        (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // more than one mode control high at once is never legal
    always @(negedge clk) begin
        if (rst_n && (int'(bus.run) + int'(bus.wwrite)
                      + int'(bus.bwrite)) > 1)
            ovl++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic layer_desc_t mk(
        input logic [4:0]  iw_v,
        input logic [11:0] ds_v,
        input logic [7:0]  b,
        input logic [12:0] w,
        input logic [15:0] n
    );
        layer_desc_t d;
        d       = '0;
        d.ss    = 12'h0A5;
        d.id    = 4'd2;
        d.is    = 10'd100;
        d.ih    = 5'd8;
        d.iw    = iw_v;
        d.ds    = ds_v;
        d.od    = 4'd1;
        d.os    = 10'd50;
        d.oh    = 5'd4;
        d.ow    = 5'd6;
        d.fs    = 8'd9;
        d.kh    = 3'd3;
        d.kw    = 3'd5;
        d.bcnt  = b;
        d.wcnt  = w;
        d.nsamp = n;
        return d;
    endfunction

    task automatic write_desc(input logic [2:0] slot,
                              input layer_desc_t d);
        bus.cfg_we    = 1'b1;
        bus.cfg_layer = slot;
        bus.cfg_data  = d;
        step();
        bus.cfg_we    = 1'b0;
    endtask

    task automatic feed_src(input int n);
        bus.src_valid = 1'b1;
        repeat (n) step();
        bus.src_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", bus.done); end
        checks++; if ({bus.run, bus.wwrite, bus.bwrite} !== 3'b000) begin errors++; $display("FAIL rst_ctl: got %b want 000", {bus.run, bus.wwrite, bus.bwrite}); end
        checks++; if (bus.layer_idx !== 3'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", bus.layer_idx); end
        checks++; if (bus.iw !== 5'd0 || bus.ss !== 12'd0 || bus.kw !== 3'd0) begin errors++; $display("FAIL rst_geo: got iw=%0d ss=%0d kw=%0d want 0", bus.iw, bus.ss, bus.kw); end
    endtask

    task automatic test_one_layer();
        write_desc(3'd0, mk(5'd7, 12'd0, 8'd1, 13'd3, 16'd0));
        bus.num_layers = 4'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.bwrite !== 1'b0) begin errors++; $display("FAIL t1_fetch: got busy=%0b bwrite=%0b want 1 0", bus.busy, bus.bwrite); end
        step();
        checks++; if (bus.bwrite !== 1'b1) begin errors++; $display("FAIL t1_loadb: got %0b want 1", bus.bwrite); end
        checks++; if (bus.iw !== 5'd7 || bus.kw !== 3'd5 || bus.ss !== 12'h0A5) begin errors++; $display("FAIL t1_geo: got iw=%0d kw=%0d ss=%0h want 7 5 a5", bus.iw, bus.kw, bus.ss); end
        bus.src_valid = 1'b1;
        step();
        checks++; if (bus.bwrite !== 1'b1 || bus.wwrite !== 1'b0) begin errors++; $display("FAIL t1_beat1: got b=%0b w=%0b want 1 0", bus.bwrite, bus.wwrite); end
        step();
        bus.src_valid = 1'b0;
        checks++; if (bus.bwrite !== 1'b1 || bus.wwrite !== 1'b0) begin errors++; $display("FAIL t1_gapb: got b=%0b w=%0b want 1 0", bus.bwrite, bus.wwrite); end
        step();
        checks++; if (bus.bwrite !== 1'b0 || bus.wwrite !== 1'b1) begin errors++; $display("FAIL t1_loadw: got b=%0b w=%0b want 0 1", bus.bwrite, bus.wwrite); end
        bus.src_valid = 1'b1;
        repeat (3) step();
        checks++; if (bus.wwrite !== 1'b1 || bus.run !== 1'b0) begin errors++; $display("FAIL t1_w3: got w=%0b r=%0b want 1 0", bus.wwrite, bus.run); end
        step();
        bus.src_valid = 1'b0;
        step();
        checks++; if (bus.wwrite !== 1'b0 || bus.run !== 1'b1) begin errors++; $display("FAIL t1_run: got w=%0b r=%0b want 0 1", bus.wwrite, bus.run); end
        bus.dst_valid = 1'b1;
        step();
        bus.dst_valid = 1'b0;
        checks++; if (bus.run !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL t1_next: got r=%0b busy=%0b done=%0b want 0 1 0", bus.run, bus.busy, bus.done); end
        step();
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL t1_done: got done=%0b busy=%0b want 1 0", bus.done, bus.busy); end
        step();
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse: got %0b want 0", bus.done); end
    endtask

    task automatic test_two_layers();
        write_desc(3'd0, mk(5'd27, 12'd0, 8'd0, 13'd0, 16'd0));
        write_desc(3'd1, mk(5'd11, 12'd0, 8'd0, 13'd0, 16'd0));
        bus.num_layers = 4'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        checks++; if (bus.iw !== 5'd27 || bus.layer_idx !== 3'd0) begin errors++; $display("FAIL t2_l0: got iw=%0d idx=%0d want 27 0", bus.iw, bus.layer_idx); end
        feed_src(1);
        feed_src(1);
        bus.dst_valid = 1'b1;
        step();
        bus.dst_valid = 1'b0;
        step();
        checks++; if (bus.layer_idx !== 3'd1 || bus.iw !== 5'd27 || bus.done !== 1'b0) begin errors++; $display("FAIL t2_idx: got idx=%0d iw=%0d done=%0b want 1 27 0", bus.layer_idx, bus.iw, bus.done); end
        step();
        checks++; if (bus.iw !== 5'd11 || bus.bwrite !== 1'b1) begin errors++; $display("FAIL t2_iw: got iw=%0d b=%0b want 11 1", bus.iw, bus.bwrite); end
        feed_src(1);
        feed_src(1);
        bus.dst_valid = 1'b1;
        step();
        bus.dst_valid = 1'b0;
        step();
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL t2_done: got done=%0b busy=%0b want 1 0", bus.done, bus.busy); end
        checks++; if (ovl !== 0) begin errors++; $display("FAIL t2_overlap: got %0d want 0", ovl); end
        step();
    endtask

    task automatic test_gap_hold();
        write_desc(3'd0, mk(5'd3, 12'd0, 8'd1, 13'd0, 16'd0));
        bus.num_layers = 4'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.src_valid = 1'b1;
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.bwrite !== 1'b1 || bus.wwrite !== 1'b0) begin errors++; $display("FAIL t3_hold%0d: got b=%0b w=%0b want 1 0", i, bus.bwrite, bus.wwrite); end
        end
        bus.src_valid = 1'b0;
        step();
        checks++; if (bus.bwrite !== 1'b0 || bus.wwrite !== 1'b1) begin errors++; $display("FAIL t3_release: got b=%0b w=%0b want 0 1", bus.bwrite, bus.wwrite); end
        feed_src(1);
        checks++; if (bus.run !== 1'b1) begin errors++; $display("FAIL t3_run: got %0b want 1", bus.run); end
        bus.dst_valid = 1'b1;
        step();
        bus.dst_valid = 1'b0;
        step();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL t3_done: got %0b want 1", bus.done); end
        step();
    endtask

    task automatic test_run_count();
        int   beats;
        int   cyc;
        logic rdy;
        beats = 0;
        cyc   = 0;
        rdy   = 1'b1;
        write_desc(3'd0, mk(5'd5, 12'd9, 8'd0, 13'd0, 16'd2));
        bus.num_layers = 4'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        feed_src(1);
        feed_src(1);
        checks++; if (bus.run !== 1'b1) begin errors++; $display("FAIL t4_run: got %0b want 1", bus.run); end
        bus.dst_valid = 1'b1;
        while (bus.run === 1'b1 && cyc < 200) begin
            bus.dst_ready = rdy;
            step();
            if (rdy) beats++;
            rdy = ~rdy;
            cyc++;
        end
        bus.dst_valid = 1'b0;
        bus.dst_ready = 1'b1;
        checks++; if (beats !== 30) begin errors++; $display("FAIL t4_beats: got %0d want 30", beats); end
        checks++; if (cyc !== 59) begin errors++; $display("FAIL t4_cycles: got %0d want 59", cyc); end
        step();
        checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL t4_done: got %0b want 1", bus.done); end
        step();
    endtask

    task automatic test_abort();
        write_desc(3'd0, mk(5'd17, 12'd0, 8'd0, 13'd3, 16'd0));
        bus.num_layers = 4'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        bus.cfg_we    = 1'b1;
        bus.cfg_layer = 3'd0;
        bus.cfg_data  = mk(5'd30, 12'd0, 8'd0, 13'd0, 16'd0);
        bus.src_valid = 1'b1;
        step();
        bus.cfg_we    = 1'b0;
        bus.src_valid = 1'b0;
        step();
        checks++; if (bus.wwrite !== 1'b1) begin errors++; $display("FAIL t5_loadw: got %0b want 1", bus.wwrite); end
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        checks++; if ({bus.run, bus.wwrite, bus.bwrite, bus.busy} !== 4'b0000) begin errors++; $display("FAIL t5_abort: got %b want 0000", {bus.run, bus.wwrite, bus.bwrite, bus.busy}); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL t5_nodone0: got %0b want 0", bus.done); end
        step();
        checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL t5_nodone1: got done=%0b busy=%0b want 0 0", bus.done, bus.busy); end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        checks++; if (bus.iw !== 5'd17 || bus.bwrite !== 1'b1) begin errors++; $display("FAIL t5_slot: got iw=%0d b=%0b want 17 1", bus.iw, bus.bwrite); end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.bwrite !== 1'b0) begin errors++; $display("FAIL t5_abort2: got busy=%0b b=%0b want 0 0", bus.busy, bus.bwrite); end
    endtask

    task automatic test_reset_mid_run();
        write_desc(3'd0, mk(5'd21, 12'd0, 8'd0, 13'd0, 16'd0));
        write_desc(3'd1, mk(5'd9, 12'd3, 8'd0, 13'd0, 16'd0));
        bus.num_layers = 4'd2;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        feed_src(1);
        feed_src(1);
        bus.dst_valid = 1'b1;
        step();
        bus.dst_valid = 1'b0;
        step();
        step();
        feed_src(1);
        feed_src(1);
        checks++; if (bus.run !== 1'b1 || bus.layer_idx !== 3'd1 || bus.iw !== 5'd9) begin errors++; $display("FAIL t6_run: got r=%0b idx=%0d iw=%0d want 1 1 9", bus.run, bus.layer_idx, bus.iw); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if ({bus.run, bus.wwrite, bus.bwrite, bus.busy, bus.done} !== 5'b00000) begin errors++; $display("FAIL t6_ctl: got %b want 00000", {bus.run, bus.wwrite, bus.bwrite, bus.busy, bus.done}); end
        checks++; if (bus.layer_idx !== 3'd0 || bus.iw !== 5'd0 || bus.ds !== 12'd0) begin errors++; $display("FAIL t6_regs: got idx=%0d iw=%0d ds=%0d want 0 0 0", bus.layer_idx, bus.iw, bus.ds); end
        bus.num_layers = 4'd1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        checks++; if (bus.iw !== 5'd21 || bus.bwrite !== 1'b1) begin errors++; $display("FAIL t6_restart: got iw=%0d b=%0b want 21 1", bus.iw, bus.bwrite); end
        feed_src(1);
        feed_src(1);
        bus.dst_valid = 1'b1;
        step();
        bus.dst_valid = 1'b0;
        step();
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL t6_done: got done=%0b busy=%0b want 1 0", bus.done, bus.busy); end
        step();
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_layer  = '0;
        bus.cfg_data   = '0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.num_layers = 4'd1;
        bus.src_valid  = 1'b0;
        bus.src_ready  = 1'b1;
        bus.dst_valid  = 1'b0;
        bus.dst_ready  = 1'b1;
`ifdef SEQ_PERF_EN
        bus.perf_sel   = '0;
`endif
        repeat (2) step();
        rst_n = 1'b1;
        test_reset();
        test_one_layer();
        test_two_layers();
        test_gap_hold();
        test_run_count();
        test_abort();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
